// File: rtl/cpu_io_pkg.sv
// Shared constants for the CPU IN/OUT port responder.
// Port numbers, handshake state encoding, status bit layout.
package cpu_io_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } io_state_t;

  localparam logic [7:0] PORT_OUT0   = 8'd0;
  localparam logic [7:0] PORT_OUT1   = 8'd1;
  localparam logic [7:0] PORT_OUT2   = 8'd2;
  localparam logic [7:0] PORT_OUT3   = 8'd3;
  localparam logic [7:0] PORT_FIFO   = 8'd4;
  localparam logic [7:0] PORT_STATUS = 8'd5;
  localparam logic [7:0] PORT_TIMER  = 8'd6;

  localparam int STAT_NE      = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_CNT_LSB = 4;

endpackage

// File: rtl/io_fifo.sv
// Byte FIFO for external input producers.
// push/din in, pop/dout out, full/empty/count status; sync rst.
module io_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cpu_io_responder.sv
// CPU IN/OUT port responder: req/ack handshake, 4 output latches,
// input FIFO, status reg, optional timer (macro IOPORT_TIMER_EN).
// Ports: clk, rst, io_req/io_wr/io_port/io_wdata in; io_ack/io_rdata
// out; out0..out3; in_valid/in_data in, in_ready out.
module cpu_io_responder
  import cpu_io_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMER_DIV  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       io_req,
  input  logic       io_wr,
  input  logic [7:0] io_port,
  input  logic [7:0] io_wdata,
  output logic       io_ack,
  output logic [7:0] io_rdata,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  io_state_t     state;
  io_state_t     state_nx;
  logic          take;
  logic [7:0]    out_q [4];
  logic [7:0]    rd_nx;
  logic [7:0]    status;
  logic [7:0]    tmr_val;
  logic          is_out;
  logic          wr_out;
  logic          pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  io_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .din   (in_data),
    .pop   (take && pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign in_ready = !fifo_full;
  assign io_ack   = (state == ACK);
  assign is_out   = (io_port[7:2] == 6'd0);
  assign out0     = out_q[0];
  assign out1     = out_q[1];
  assign out2     = out_q[2];
  assign out3     = out_q[3];

  always_comb begin
    status                      = '0;
    status[STAT_NE]             = !fifo_empty;
    status[STAT_FULL]           = fifo_full;
    status[STAT_CNT_LSB +: 4]   = 4'(fifo_count);
  end

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    unique case (state)
      IDLE: if (io_req) begin
        take     = 1'b1;
        state_nx = ACK;
      end
      ACK: if (!io_req) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef IOPORT_TIMER_EN
  logic tmr_clr;
`endif

  always_comb begin
    rd_nx  = 8'hFF;
    pop    = 1'b0;
    wr_out = 1'b0;
`ifdef IOPORT_TIMER_EN
    tmr_clr = 1'b0;
`endif
    unique case (1'b1)
      is_out: begin
        rd_nx  = out_q[io_port[1:0]];
        wr_out = io_wr;
      end
      io_port == PORT_FIFO: begin
        rd_nx = fifo_empty ? 8'h00 : fifo_dout;
        pop   = !io_wr && !fifo_empty;
      end
      io_port == PORT_STATUS: rd_nx = status;
      io_port == PORT_TIMER: begin
        rd_nx = tmr_val;
`ifdef IOPORT_TIMER_EN
        tmr_clr = io_wr;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      io_rdata <= '0;
      for (int i = 0; i < 4; i++) out_q[i] <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        io_rdata <= rd_nx;
        if (wr_out) out_q[io_port[1:0]] <= io_wdata;
      end
    end
  end

`ifdef IOPORT_TIMER_EN
  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  logic [PW-1:0] pre;
  logic [7:0]    tmr;
  logic          wrap;

  assign wrap    = (pre == PW'(TIMER_DIV - 1));
  assign tmr_val = tmr;

  // Clear beats a coincident increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      tmr <= '0;
    end else begin
      pre <= wrap ? '0 : pre + 1'b1;
      if (take && tmr_clr) tmr <= '0;
      else if (wrap)       tmr <= tmr + 1'b1;
    end
  end
`else
  logic unused_div;
  assign unused_div = |TIMER_DIV;
  assign tmr_val    = 8'h00;
`endif

endmodule
